interp2_upsampler: RTL



---
 rtl/interp2_pkg.sv | 29 ++
 rtl/interp2_midpoint.sv | 15 +
 rtl/interp2_upsampler.sv | 91 +++++++++
 3 files changed

// File: rtl/interp2_pkg.sv
// Shared types and midpoint arithmetic for the 2x interpolating upsampler.
// Define INTERP2_ROUND_EN to round midpoints half up instead of flooring.
package interp2_pkg;

    // Widest operand the midpoint helper supports; callers zero-extend into it.
    localparam int MID_MAX_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MID  = 2'd1,
        S_SMP  = 2'd2
    } state_t;

    // The sum carries one extra bit, so neither floor nor round-half-up can wrap.
    function automatic logic [MID_MAX_W-1:0] midpoint(
        input logic [MID_MAX_W-1:0] a,
        input logic [MID_MAX_W-1:0] b
    );
        logic [MID_MAX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef INTERP2_ROUND_EN
        sum = sum + {{MID_MAX_W{1'b0}}, 1'b1};
`else
        sum = sum;
`endif
        return MID_MAX_W'(sum >> 1);
    endfunction

endpackage

// File: rtl/interp2_midpoint.sv
// Combinational midpoint of two unsigned samples (floor, or round half up
// when INTERP2_ROUND_EN is defined).
module interp2_midpoint
    import interp2_pkg::*;
#(
    parameter int G_DATA_SIZE = 10
) (
    input  logic [G_DATA_SIZE-1:0] a_i,
    input  logic [G_DATA_SIZE-1:0] b_i,
    output logic [G_DATA_SIZE-1:0] mid_o
);

    assign mid_o = G_DATA_SIZE'(midpoint(MID_MAX_W'(a_i), MID_MAX_W'(b_i)));

endmodule

// File: rtl/interp2_upsampler.sv
// Streaming 2x linear-interpolation upsampler: each sample emits the midpoint
// with its predecessor, then itself. Rounding selected by INTERP2_ROUND_EN.
module interp2_upsampler
    import interp2_pkg::*;
#(
    parameter int G_DATA_SIZE = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [G_DATA_SIZE-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [G_DATA_SIZE-1:0] out_data
);

    state_t                   state_q, state_d;
    // last_q is both the predecessor for the next midpoint and the sample still
    // to be emitted after a midpoint; the midpoint itself lives in out_data_q.
    logic [G_DATA_SIZE-1:0]   last_q, last_d;
    logic [G_DATA_SIZE-1:0]   out_data_q, out_data_d;
    logic                     hist_valid_q, hist_valid_d;
    logic [G_DATA_SIZE-1:0]   mid_calc;
    logic                     accept;

    interp2_midpoint #(
        .G_DATA_SIZE(G_DATA_SIZE)
    ) u_midpoint (
        .a_i   (last_q),
        .b_i   (in_data),
        .mid_o (mid_calc)
    );

    // The sample slot frees up exactly when the pending sample output is taken.
    assign in_ready  = !reset && ((state_q == S_IDLE) || ((state_q == S_SMP) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q != S_IDLE);
    assign out_data  = out_data_q;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        out_data_d   = out_data_q;
        hist_valid_d = flush ? 1'b0 : hist_valid_q;
        if (accept) begin
            last_d       = in_data;
            hist_valid_d = 1'b1;
            if (hist_valid_q && !flush) begin
                out_data_d = mid_calc;
                state_d    = S_MID;
            end else begin
                out_data_d = in_data;
                state_d    = S_SMP;
            end
        end else begin
            case (state_q)
                S_MID: begin
                    if (out_ready) begin
                        out_data_d = last_q;
                        state_d    = S_SMP;
                    end
                end
                S_SMP: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_q       <= '0;
            out_data_q   <= '0;
            hist_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            out_data_q   <= out_data_d;
            hist_valid_q <= hist_valid_d;
        end
    end

endmodule
